// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: two-stage pipelined sign-magnitude adder/subtractor.
//
// Adds or subtracts two sign-magnitude operands and returns a sign-magnitude
// result one bit wider. Zero results are always +0 (out_zero = 1). The valid/ready
// handshake gives full back-pressure through both register stages.
//
// Optional feature (compile-time macro SM_ACC_EN): a running sign-magnitude
// accumulator of width AW fed by every output transfer. It saturates with a sticky
// overflow flag. When the macro is undefined, acc_clr and the acc_* ports are absent.
//
// Parameters:
//   MW : magnitude width of each operand
//   AW : accumulator magnitude width (SM_ACC_EN only, must be >= MW+1)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake
//   in_sign_a, in_mag_a  operand A
//   in_sign_b, in_mag_b  operand B
//   in_sub               1 = A - B
//   out_valid/out_ready  result handshake
//   out_sign, out_mag    result (MW+1 bit magnitude)
//   out_zero             result magnitude is zero
//   acc_clr              clear accumulator (SM_ACC_EN)
//   acc_sign, acc_mag    accumulator value (SM_ACC_EN)
//   acc_ovf              sticky accumulator overflow (SM_ACC_EN)
module sm_addsub_pipe #(
  parameter int unsigned MW = 11,
  parameter int unsigned AW = MW + 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign_a,
  input  logic [MW-1:0] in_mag_a,
  input  logic          in_sign_b,
  input  logic [MW-1:0] in_mag_b,
  input  logic          in_sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [MW:0]   out_mag,
  output logic          out_zero
`ifdef SM_ACC_EN
  ,
  input  logic          acc_clr,
  output logic          acc_sign,
  output logic [AW-1:0] acc_mag,
  output logic          acc_ovf
`endif
);

  if (AW < MW + 1) begin : g_aw_check
    $error("sm_addsub_pipe: AW must be at least MW+1");
  end

  // Handshake chain; combinational from out_ready, no skid buffer.
  logic s1_valid;
  logic s2_valid;
  logic s1_ready;
  logic s2_ready;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1: effective sign, magnitude ordering, result sign on subtract
  // ---------------------------------------------------------------------------
  logic          sb_eff;
  logic          a_ge_b;
  logic [MW-1:0] big_d;
  logic [MW-1:0] small_d;

  always_comb begin
    sb_eff  = in_sign_b ^ in_sub;
    a_ge_b  = (in_mag_a >= in_mag_b);
    big_d   = a_ge_b ? in_mag_a : in_mag_b;
    small_d = a_ge_b ? in_mag_b : in_mag_a;
  end

  logic          s1_sa;
  logic          s1_eff_sub;
  logic          s1_res_sign;
  logic [MW-1:0] s1_big;
  logic [MW-1:0] s1_small;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sa       <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_res_sign <= 1'b0;
      s1_big      <= '0;
      s1_small    <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
      end
      // Data only moves on an accepted beat so idle inputs never disturb state.
      if (in_valid && s1_ready) begin
        s1_sa       <= in_sign_a;
        s1_eff_sub  <= in_sign_a ^ sb_eff;
        // On a tie the larger operand is A, so the sign falls back to A.
        s1_res_sign <= a_ge_b ? in_sign_a : sb_eff;
        s1_big      <= big_d;
        s1_small    <= small_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: add/subtract and canonical zero
  // ---------------------------------------------------------------------------
  logic [MW:0] mag_d;
  logic        zero_d;
  logic        sign_d;

  always_comb begin
    if (s1_eff_sub) begin
      mag_d = {1'b0, s1_big} - {1'b0, s1_small};
    end else begin
      mag_d = {1'b0, s1_big} + {1'b0, s1_small};
    end
    zero_d = (mag_d == '0);
    if (zero_d) begin
      sign_d = 1'b0;
    end else if (s1_eff_sub) begin
      sign_d = s1_res_sign;
    end else begin
      sign_d = s1_sa;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_zero <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid <= s1_valid;
      end
      // Outputs hold while stalled because they only load when stage 2 frees up.
      if (s1_valid && s2_ready) begin
        out_sign <= sign_d;
        out_mag  <= mag_d;
        out_zero <= zero_d;
      end
    end
  end

`ifdef SM_ACC_EN
  // ---------------------------------------------------------------------------
  // Running accumulator, fed by each output transfer
  // ---------------------------------------------------------------------------
  logic          out_xfer;
  logic [AW:0]   acc_ext;
  logic [AW:0]   res_ext;
  logic [AW:0]   acc_raw;
  logic          acc_sat;
  logic          acc_sign_d;
  logic [AW-1:0] acc_mag_d;

  assign out_xfer = s2_valid && out_ready;

  always_comb begin
    acc_ext    = {1'b0, acc_mag};
    res_ext    = (AW + 1)'(out_mag);
    acc_raw    = '0;
    acc_sat    = 1'b0;
    acc_sign_d = acc_sign;
    acc_mag_d  = acc_mag;
    if (acc_sign == out_sign) begin
      acc_raw = acc_ext + res_ext;
      if (acc_raw[AW]) begin
        acc_sat   = 1'b1;
        acc_mag_d = '1;
      end else begin
        acc_mag_d = acc_raw[AW-1:0];
      end
      acc_sign_d = acc_sign;
    end else if (acc_ext >= res_ext) begin
      acc_raw    = acc_ext - res_ext;
      acc_mag_d  = acc_raw[AW-1:0];
      acc_sign_d = acc_sign;
    end else begin
      acc_raw    = res_ext - acc_ext;
      acc_mag_d  = acc_raw[AW-1:0];
      acc_sign_d = out_sign;
    end
    if (acc_mag_d == '0) begin
      acc_sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      acc_ovf  <= 1'b0;
    end else if (acc_clr) begin
      // A clear that coincides with a transfer restarts from that result.
      acc_ovf <= 1'b0;
      if (out_xfer) begin
        acc_sign <= out_sign;
        acc_mag  <= (AW)'(out_mag);
      end else begin
        acc_sign <= 1'b0;
        acc_mag  <= '0;
      end
    end else if (out_xfer) begin
      acc_sign <= acc_sign_d;
      acc_mag  <= acc_mag_d;
      acc_ovf  <= acc_ovf | acc_sat;
    end
  end
`endif

endmodule

// File: tb/tb_sm_addsub_pipe.sv
module tb_sm_addsub_pipe;

  localparam int unsigned MW = 11;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign_a = 1'b0;
  logic [MW-1:0] in_mag_a = '0;
  logic          in_sign_b = 1'b0;
  logic [MW-1:0] in_mag_b = '0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [MW:0]   out_mag;
  logic          out_zero;
`ifdef SM_ACC_EN
  logic          acc_clr = 1'b0;
  logic          acc_sign;
  logic [AW-1:0] acc_mag;
  logic          acc_ovf;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          sa;
    logic [MW-1:0] ma;
    logic          sb;
    logic [MW-1:0] mb;
    logic          sub;
    logic          es;
    logic [MW:0]   em;
    logic          ez;
  } vec_t;

  sm_addsub_pipe #(.MW(MW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign_a (in_sign_a),
    .in_mag_a  (in_mag_a),
    .in_sign_b (in_sign_b),
    .in_mag_b  (in_mag_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_zero  (out_zero)
`ifdef SM_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .acc_sign  (acc_sign),
    .acc_mag   (acc_mag),
    .acc_ovf   (acc_ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input vec_t v);
    in_sign_a = v.sa;
    in_mag_a  = v.ma;
    in_sign_b = v.sb;
    in_mag_b  = v.mb;
    in_sub    = v.sub;
  endtask

  // Accepts one beat on an empty pipe and stops at the negedge after the accept.
  task automatic send_one(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== '0 || out_zero !== 1'b0
        || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: got valid=%0b sign=%0b mag=%0d zero=%0b rdy=%0b, want 0 0 0 0 1",
               out_valid, out_sign, out_mag, out_zero, in_ready);
    end
`ifdef SM_ACC_EN
    checks++;
    if (acc_sign !== 1'b0 || acc_mag !== '0 || acc_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_acc: got sign=%0b mag=%0d ovf=%0b, want 0 0 0",
               acc_sign, acc_mag, acc_ovf);
    end
`endif
  endtask

  task automatic test_add();
    vec_t v [2];
    v[0] = '{1'b0, 11'd1000, 1'b0, 11'd24, 1'b0, 1'b0, 12'd1024, 1'b0};
    v[1] = '{1'b1, 11'd1, 1'b1, 11'd2046, 1'b0, 1'b1, 12'd2047, 1'b0};
    for (int i = 0; i < 2; i++) begin
      send_one(v[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL add_latency[%0d]: got valid=%0b after 1 cycle, want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sign !== v[i].es || out_mag !== v[i].em
          || out_zero !== v[i].ez) begin
        failures++;
        $display("FAIL add[%0d]: got v=%0b s=%0b m=%0d z=%0b, want v=1 s=%0b m=%0d z=%0b",
                 i, out_valid, out_sign, out_mag, out_zero, v[i].es, v[i].em, v[i].ez);
      end
    end
  endtask

  task automatic test_zero();
    vec_t v [3];
    v[0] = '{1'b1, 11'd5, 1'b0, 11'd5, 1'b0, 1'b0, 12'd0, 1'b1};
    v[1] = '{1'b1, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0, 12'd0, 1'b1};
    v[2] = '{1'b0, 11'd5, 1'b0, 11'd5, 1'b1, 1'b0, 12'd0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i]);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sign !== v[i].es || out_mag !== v[i].em
          || out_zero !== v[i].ez) begin
        failures++;
        $display("FAIL zero[%0d]: got v=%0b s=%0b m=%0d z=%0b, want v=1 s=%0b m=%0d z=%0b",
                 i, out_valid, out_sign, out_mag, out_zero, v[i].es, v[i].em, v[i].ez);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v [3];
    v[0] = '{1'b0, 11'd2047, 1'b1, 11'd2047, 1'b1, 1'b0, 12'd4094, 1'b0};
    v[1] = '{1'b0, 11'd3, 1'b0, 11'd10, 1'b1, 1'b1, 12'd7, 1'b0};
    v[2] = '{1'b1, 11'd10, 1'b1, 11'd3, 1'b1, 1'b1, 12'd7, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i]);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sign !== v[i].es || out_mag !== v[i].em
          || out_zero !== v[i].ez) begin
        failures++;
        $display("FAIL sub[%0d]: got v=%0b s=%0b m=%0d z=%0b, want v=1 s=%0b m=%0d z=%0b",
                 i, out_valid, out_sign, out_mag, out_zero, v[i].es, v[i].em, v[i].ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [8];
    bit   pat [4];
    int   sent = 0;
    int   recv = 0;
    int   occ = 0;
    int   cyc = 0;
    logic exp_rdy;
    logic p_stall = 1'b0;
    logic p_sign = 1'b0;
    logic [MW:0] p_mag = '0;
    logic p_zero = 1'b0;
    v[0] = '{1'b0, 11'd100, 1'b0, 11'd23, 1'b0, 1'b0, 12'd123, 1'b0};
    v[1] = '{1'b1, 11'd50, 1'b0, 11'd20, 1'b0, 1'b1, 12'd30, 1'b0};
    v[2] = '{1'b0, 11'd7, 1'b0, 11'd7, 1'b1, 1'b0, 12'd0, 1'b1};
    v[3] = '{1'b1, 11'd300, 1'b1, 11'd200, 1'b0, 1'b1, 12'd500, 1'b0};
    v[4] = '{1'b0, 11'd1, 1'b0, 11'd2, 1'b1, 1'b1, 12'd1, 1'b0};
    v[5] = '{1'b0, 11'd2047, 1'b0, 11'd2047, 1'b0, 1'b0, 12'd4094, 1'b0};
    v[6] = '{1'b1, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0, 12'd0, 1'b1};
    v[7] = '{1'b0, 11'd15, 1'b1, 11'd15, 1'b1, 1'b0, 12'd30, 1'b0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (recv < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) drive(v[sent]);
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL b2b_ready cyc%0d: got %0b, want %0b", cyc, in_ready, exp_rdy);
      end
      if (p_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_sign !== p_sign || out_mag !== p_mag
            || out_zero !== p_zero) begin
          failures++;
          $display("FAIL b2b_hold cyc%0d: got v=%0b s=%0b m=%0d z=%0b, want v=1 s=%0b m=%0d z=%0b",
                   cyc, out_valid, out_sign, out_mag, out_zero, p_sign, p_mag, p_zero);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_sign !== v[recv].es || out_mag !== v[recv].em || out_zero !== v[recv].ez) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got s=%0b m=%0d z=%0b, want s=%0b m=%0d z=%0b",
                   recv, out_sign, out_mag, out_zero, v[recv].es, v[recv].em, v[recv].ez);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      occ = sent - recv;
      p_stall = out_valid && !out_ready;
      p_sign  = out_sign;
      p_mag   = out_mag;
      p_zero  = out_zero;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, want 8", recv);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    vec_t b0;
    vec_t b1;
    b0 = '{1'b0, 11'd11, 1'b0, 11'd22, 1'b0, 1'b0, 12'd33, 1'b0};
    b1 = '{1'b0, 11'd44, 1'b0, 11'd55, 1'b0, 1'b0, 12'd99, 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    drive(b0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_mag !== 12'd33) begin
      failures++;
      $display("FAIL rst_fill: got v=%0b m=%0d, want v=1 m=33", out_valid, out_mag);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_mag !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async: got v=%0b m=%0d rdy=%0b, want 0 0 1",
               out_valid, out_mag, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale[%0d]: got valid=%0b, want 0", i, out_valid);
      end
    end
  endtask

`ifdef SM_ACC_EN
  task automatic test_accumulator();
    vec_t p;
    vec_t n;
    vec_t q;
    p = '{1'b0, 11'd2047, 1'b0, 11'd0, 1'b0, 1'b0, 12'd2047, 1'b0};
    n = '{1'b1, 11'd9, 1'b1, 11'd0, 1'b0, 1'b1, 12'd9, 1'b0};
    q = '{1'b0, 11'd20, 1'b0, 11'd0, 1'b0, 1'b0, 12'd20, 1'b0};
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    checks++;
    if (acc_sign !== 1'b0 || acc_mag !== '0 || acc_ovf !== 1'b0) begin
      failures++;
      $display("FAIL acc_clr: got s=%0b m=%0d o=%0b, want 0 0 0", acc_sign, acc_mag, acc_ovf);
    end
    drive(p);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (acc_sign !== 1'b0 || acc_mag !== 12'd4095 || acc_ovf !== 1'b1) begin
      failures++;
      $display("FAIL acc_sat: got s=%0b m=%0d o=%0b, want 0 4095 1", acc_sign, acc_mag, acc_ovf);
    end
    out_ready = 1'b0;
    drive(n);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || acc_mag !== 12'd4095 || acc_ovf !== 1'b1) begin
      failures++;
      $display("FAIL acc_hold: got v=%0b m=%0d o=%0b, want 1 4095 1", out_valid, acc_mag, acc_ovf);
    end
    out_ready = 1'b1;
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    checks++;
    if (acc_sign !== 1'b1 || acc_mag !== 12'd9 || acc_ovf !== 1'b0) begin
      failures++;
      $display("FAIL acc_clr_load: got s=%0b m=%0d o=%0b, want 1 9 0", acc_sign, acc_mag, acc_ovf);
    end
    send_one(q);
    repeat (2) @(negedge clk);
    checks++;
    if (acc_sign !== 1'b0 || acc_mag !== 12'd11 || acc_ovf !== 1'b0) begin
      failures++;
      $display("FAIL acc_cross: got s=%0b m=%0d o=%0b, want 0 11 0", acc_sign, acc_mag, acc_ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_zero();
    test_sub();
    test_back_to_back();
    test_reset_in_flight();
`ifdef SM_ACC_EN
    test_accumulator();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
